// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: two-sprite hit test, ROM addressing and A-over-B resolve; SPRITE_FLIP_EN enables horizontal mirroring
module sprite_pixel_fetch #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int H_BITS = 10,
  parameter int V_BITS = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [H_BITS-1:0]                a_x,
  input  logic [H_BITS-1:0]                b_x,
  input  logic [V_BITS-1:0]                a_y,
  input  logic [V_BITS-1:0]                b_y,
  input  logic                             a_face,
  input  logic                             b_face,
  input  logic [H_BITS-1:0]                h_cnt,
  input  logic [V_BITS-1:0]                v_cnt,
  input  logic                             video_on,
  output logic [$clog2(SPR_W*SPR_H)-1:0]   a_rom_addr,
  output logic [$clog2(SPR_W*SPR_H)-1:0]   b_rom_addr,
  input  logic [3:0]                       a_rom_data,
  input  logic [3:0]                       b_rom_data,
  output logic [3:0]                       color_index,
  output logic                             is_b,
  output logic                             pix_valid
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int AW = XW + YW;

  // Widened compares so a sprite near the right/bottom edge clips instead of wrapping to 0.
  function automatic logic in_box(input logic [H_BITS-1:0] h, input logic [H_BITS-1:0] x,
                                  input logic [V_BITS-1:0] v, input logic [V_BITS-1:0] y);
    return ({1'b0, h} >= {1'b0, x}) && ({1'b0, h} < {1'b0, x} + (H_BITS+1)'(SPR_W)) &&
           ({1'b0, v} >= {1'b0, y}) && ({1'b0, v} < {1'b0, y} + (V_BITS+1)'(SPR_H));
  endfunction

  // Mirrored column is SPR_W-1-dx, which for a power-of-two width is the bitwise inverse.
  function automatic logic [AW-1:0] addr_of(input logic [H_BITS-1:0] h, input logic [H_BITS-1:0] x,
                                            input logic [V_BITS-1:0] v, input logic [V_BITS-1:0] y,
                                            input logic flip);
    logic [XW-1:0] dx;
    dx = XW'(h - x);
    return {YW'(v - y), flip ? ~dx : dx};
  endfunction

  logic [H_BITS-1:0] ax_q, ax_d, bx_q, bx_d;
  logic [V_BITS-1:0] ay_q, ay_d, by_q, by_d;
  logic              shadow_ok_q, shadow_ok_d;
  logic              a_hit1_q, a_hit1_d, b_hit1_q, b_hit1_d;
  logic              a_hit2_q, a_hit2_d, b_hit2_q, b_hit2_d;
  logic [AW-1:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic              a_flip, b_flip;

`ifdef SPRITE_FLIP_EN
  logic af_q, af_d, bf_q, bf_d;
  // Face bits shadowed alongside positions so mirroring also changes only at frame boundaries.
  always_comb begin
    af_d = frame_start ? a_face : af_q;
    bf_d = frame_start ? b_face : bf_q;
  end
  // Face shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
      bf_q <= 1'b0;
    end else begin
      af_q <= af_d;
      bf_q <= bf_d;
    end
  end
  assign a_flip = af_q;
  assign b_flip = bf_q;
`else
  logic unused_face;
  assign unused_face = a_face ^ b_face;
  assign a_flip = 1'b0;
  assign b_flip = 1'b0;
`endif

  // Shadow capture, stage-0 hit test/address, and hit flags delayed to line up with ROM data.
  always_comb begin
    ax_d        = frame_start ? a_x : ax_q;
    ay_d        = frame_start ? a_y : ay_q;
    bx_d        = frame_start ? b_x : bx_q;
    by_d        = frame_start ? b_y : by_q;
    shadow_ok_d = shadow_ok_q | frame_start;
    a_hit1_d    = video_on && shadow_ok_q && in_box(h_cnt, ax_q, v_cnt, ay_q);
    b_hit1_d    = video_on && shadow_ok_q && in_box(h_cnt, bx_q, v_cnt, by_q);
    a_addr_d    = a_hit1_d ? addr_of(h_cnt, ax_q, v_cnt, ay_q, a_flip) : '0;
    b_addr_d    = b_hit1_d ? addr_of(h_cnt, bx_q, v_cnt, by_q, b_flip) : '0;
    a_hit2_d    = a_hit1_q;
    b_hit2_d    = b_hit1_q;
  end

  // Pipeline and shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_q        <= '0;
      ay_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      shadow_ok_q <= 1'b0;
      a_hit1_q    <= 1'b0;
      b_hit1_q    <= 1'b0;
      a_hit2_q    <= 1'b0;
      b_hit2_q    <= 1'b0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
    end else begin
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      shadow_ok_q <= shadow_ok_d;
      a_hit1_q    <= a_hit1_d;
      b_hit1_q    <= b_hit1_d;
      a_hit2_q    <= a_hit2_d;
      b_hit2_q    <= b_hit2_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
    end
  end

  assign a_rom_addr = a_addr_q;
  assign b_rom_addr = b_addr_q;

  // Resolve against the ROM's registered data; A wins any overlap, zero index is transparent.
  always_comb begin
    logic a_op, b_op;
    a_op        = a_hit2_q && (a_rom_data != 4'd0);
    b_op        = b_hit2_q && (b_rom_data != 4'd0);
    color_index = a_op ? a_rom_data : b_op ? b_rom_data : 4'd0;
    is_b        = !a_op && b_op;
    pix_valid   = a_op || b_op;
  end
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// tb_sprite_pixel_fetch: randomized and directed checks of sprite_pixel_fetch against a behavioural model
module tb_sprite_pixel_fetch;
  logic       clk = 0, rst = 1, frame_start = 0, video_on = 0;
  logic [9:0] a_x = 0, b_x = 0, a_y = 0, b_y = 0, h_cnt = 0, v_cnt = 0;
  logic       a_face = 0, b_face = 0;
  logic [9:0] a_rom_addr, b_rom_addr;
  logic [3:0] a_rom_data = 0, b_rom_data = 0, color_index;
  logic       is_b, pix_valid;

  int total = 0, bad = 0;
  logic [3:0] rom_a [1024];
  logic [3:0] rom_b [1024];

  int m_ax, m_ay, m_bx, m_by;
  bit m_af, m_bf, m_ok;
  bit p_ha, p_hb;
  int p_aa, p_ab;

  sprite_pixel_fetch dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .a_x(a_x), .b_x(b_x), .a_y(a_y), .b_y(b_y), .a_face(a_face), .b_face(b_face),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .video_on(video_on),
    .a_rom_addr(a_rom_addr), .b_rom_addr(b_rom_addr),
    .a_rom_data(a_rom_data), .b_rom_data(b_rom_data),
    .color_index(color_index), .is_b(is_b), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rom_data <= rom_a[a_rom_addr];
    b_rom_data <= rom_b[b_rom_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input int h, input int v, input bit vid, input int x, input int y,
                                input bit f, output bit hit, output int addr);
    int dx;
    bit flip;
    flip = f;
`ifndef SPRITE_FLIP_EN
    flip = 0;
`endif
    hit  = vid && m_ok && h >= x && h < x + 32 && v >= y && v < y + 32;
    addr = 0;
    if (hit) begin
      dx   = flip ? 31 - (h - x) : h - x;
      addr = (v - y) * 32 + dx;
    end
  endfunction

  task automatic cyc(input int h, input int v, input bit vid, input bit fs);
    bit ha, hb;
    int aa, ab, ec;
    bit eb;
    h_cnt = 10'(h); v_cnt = 10'(v); video_on = vid; frame_start = fs;
    model(h, v, vid, m_ax, m_ay, m_af, ha, aa);
    model(h, v, vid, m_bx, m_by, m_bf, hb, ab);
    @(posedge clk); #1;
    chk("a_rom_addr", int'(a_rom_addr), aa);
    chk("b_rom_addr", int'(b_rom_addr), ab);
    ec = 0; eb = 0;
    if (p_ha && rom_a[p_aa] != 0) ec = int'(rom_a[p_aa]);
    else if (p_hb && rom_b[p_ab] != 0) begin ec = int'(rom_b[p_ab]); eb = 1; end
    chk("color_index", int'(color_index), ec);
    chk("is_b", int'(is_b), int'(eb));
    chk("pix_valid", int'(pix_valid), int'(ec != 0));
    p_ha = ha; p_hb = hb; p_aa = aa; p_ab = ab;
    if (fs) begin
      m_ax = int'(a_x); m_ay = int'(a_y); m_bx = int'(b_x); m_by = int'(b_y);
      m_af = a_face; m_bf = b_face; m_ok = 1;
    end
    frame_start = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #2;
    chk("rst_a_addr", int'(a_rom_addr), 0);
    chk("rst_b_addr", int'(b_rom_addr), 0);
    chk("rst_color", int'(color_index), 0);
    chk("rst_is_b", int'(is_b), 0);
    chk("rst_valid", int'(pix_valid), 0);
    m_ok = 0; m_ax = 0; m_ay = 0; m_bx = 0; m_by = 0; m_af = 0; m_bf = 0;
    p_ha = 0; p_hb = 0; p_aa = 0; p_ab = 0;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic set_pos(input int ax, input int ay, input int bx, input int by, input bit af, input bit bf);
    a_x = 10'(ax); a_y = 10'(ay); b_x = 10'(bx); b_y = 10'(by); a_face = af; b_face = bf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom_a[i] = 4'($urandom);
      rom_b[i] = 4'($urandom);
    end
    @(posedge clk); #1;
    do_reset();
    // no frame_start yet: nothing may hit anywhere
    set_pos(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) cyc($urandom_range(0, 639), $urandom_range(0, 479), 1, 0);
    for (int i = 0; i < 64; i++) cyc(i, i / 2, 1, 0);
    // basic fetch
    set_pos(100, 50, 900, 900, 0, 0);
    rom_a[101] = 4'd7;
    cyc(0, 0, 0, 1);
    cyc(105, 53, 1, 0);
    idle(2);
    // overlap priority
    set_pos(200, 200, 200, 200, 0, 0);
    rom_a[170] = 4'd0; rom_b[170] = 4'd2;
    cyc(0, 0, 0, 1);
    cyc(210, 205, 1, 0);
    idle(2);
    rom_a[170] = 4'd1;
    cyc(210, 205, 1, 0);
    idle(2);
    // edge clip, including a sprite that would wrap past column 1023 / row 1023
    set_pos(900, 900, 630, 100, 0, 0);
    rom_b[329] = 4'd5;
    cyc(0, 0, 0, 1);
    cyc(639, 110, 1, 0);
    cyc(0, 110, 1, 0);
    set_pos(1000, 1010, 630, 100, 0, 0);
    cyc(0, 0, 0, 1);
    for (int i = 1016; i < 1024; i++) cyc(i, 1020, 1, 0);
    for (int i = 0; i < 8; i++) cyc(i, 1020, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1020, i, 1, 0);
    idle(2);
    // frame latch: moving a_x without frame_start has no effect
    set_pos(100, 50, 900, 900, 0, 0);
    cyc(0, 0, 0, 1);
    a_x = 10'd300;
    for (int i = 0; i < 40; i++) cyc(96 + i, 53, 1, 0);
    cyc(305, 53, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(305, 53, 1, 0);
    cyc(105, 53, 1, 0);
    // frame_start coincident with a visible pixel uses old shadows
    a_x = 10'd100;
    cyc(105, 53, 1, 1);
    cyc(105, 53, 1, 0);
    idle(2);
    // flip
    set_pos(0, 0, 900, 900, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(3, 2, 1, 0);
    idle(2);
    // mid-operation reset clears shadows
    set_pos(100, 50, 100, 50, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(105, 53, 1, 0);
    do_reset();
    for (int i = 0; i < 40; i++) cyc(100 + i, 53, 1, 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int h, v;
      if (i % 500 == 0) set_pos($urandom_range(0, 1023), $urandom_range(0, 1023),
                                $urandom_range(0, 1023), $urandom_range(0, 1023),
                                1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 1023); v = $urandom_range(0, 1023);
      end else if ($urandom_range(0, 1) == 0) begin
        h = (m_ax + $urandom_range(0, 40) + 1020) % 1024; v = (m_ay + $urandom_range(0, 40) + 1020) % 1024;
      end else begin
        h = (m_bx + $urandom_range(0, 40) + 1020) % 1024; v = (m_by + $urandom_range(0, 40) + 1020) % 1024;
      end
      if ($urandom_range(0, 99) == 0) rom_a[$urandom_range(0, 1023)] = 4'($urandom);
      cyc(h, v, $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0);
      if (i == 2000) do_reset();
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_pixel_fetch.md
# sprite_pixel_fetch

Per-pixel sprite fetch stage that feeds the palette color decoder. From the VGA scan position it tests two 32×32 player sprites (A and B), drives their synchronous index-ROM addresses, and resolves transparency and priority. It outputs the 4-bit color index plus the is_b recolor flag, two cycles after the scan position. Sprite positions are shadow-latched once per frame so a sprite never tears mid-frame.

## Interface

Parameters:
- `SPR_W`, 32, sprite width in pixels; power of two.
- `SPR_H`, 32, sprite height in pixels; power of two.
- `H_BITS`, 10, width of the horizontal counter and X positions.
- `V_BITS`, 10, width of the vertical counter and Y positions.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  single-cycle pulse at the start of vertical blank.
- `a_x`, `b_x`  in  H_BITS  sprite top-left X; sampled only on `frame_start`.
- `a_y`, `b_y`  in  V_BITS  sprite top-left Y; sampled only on `frame_start`.
- `a_face`, `b_face`  in  1  1 = mirror horizontally; sampled on `frame_start`; ignored without the macro.
- `h_cnt`  in  H_BITS  current scan column.
- `v_cnt`  in  V_BITS  current scan row.
- `video_on`  in  1  visible-area flag.
- `a_rom_addr`, `b_rom_addr`  out  log2(SPR_W·SPR_H)  sprite ROM addresses.
- `a_rom_data`, `b_rom_data`  in  4  ROM index data; valid 1 cycle after the address.
- `color_index`  out  4  resolved palette index; 0 = transparent.
- `is_b`  out  1  1 when `color_index` comes from sprite B.
- `pix_valid`  out  1  1 when `color_index` ≠ 0.

## Operation

- **Shadow registers:**
  - On `frame_start`, all positions and face bits copy into shadows.
  - `shadow_ok` sets on the first `frame_start` after reset.
  - While `shadow_ok` = 0, neither sprite hits.
- **Hit test (stage 0):**
  - Sprite A hits when `h_cnt` ≥ x, `h_cnt` < x+SPR_W, `v_cnt` ≥ y, `v_cnt` < y+SPR_H, `video_on` = 1 and `shadow_ok` = 1. Sprite B uses the same test.
  - Sums are computed at H_BITS+1 / V_BITS+1 bits, so a sprite near the right or bottom edge clips and never wraps to column or row 0.
- **Address:**
  - dx = h_cnt − x and dy = v_cnt − y, truncated to log2(SPR_W) and log2(SPR_H) bits.
  - addr = {dy, dx}.
  - On a miss the address is 0.
- **Stage 1:** the registered hit flags track the ROM read latency.
- **Stage 2 (resolve):**
  - A opaque (A hit and data ≠ 0): output A's index, `is_b` = 0.
  - Otherwise, B opaque: output B's index, `is_b` = 1.
  - Otherwise: `color_index` = 0, `is_b` = 0.
  - A always wins an overlap.
- **Reset mid-operation:** all pipeline registers, shadows and `shadow_ok` clear immediately; outputs are 0 until a new `frame_start` is followed by a hit.

## Timing

- All outputs are reset to 0; the ROM addresses are reset to 0.
- ROM addresses are registered 1 cycle after `h_cnt`/`v_cnt`.
- `color_index`, `is_b` and `pix_valid` are registered 2 cycles after the `h_cnt`/`v_cnt` sample. The downstream sync path delays by 2 to match.
- A `frame_start` at cycle n makes the new positions effective for a scan sample at cycle n+1.
- If `frame_start` and a visible pixel coincide, that pixel uses the old shadows.
- Throughput is 1 pixel per clock with no stalls and no handshake.

## Configuration

- `SPRITE_FLIP_EN` defined:
  - A sprite whose shadowed face bit is 1 uses dx' = SPR_W−1−dx in its address.
  - Hit region is unchanged.
- Not defined:
  - Face inputs are unused; no face shadow registers exist.
  - dx is used directly.

## Test plan

- **Reset gating:** after reset, no `frame_start`; scan the full frame → `color_index` = 0 and `pix_valid` = 0 everywhere.
- **Basic fetch:**
  - Stimulus: A at (100,50); `frame_start`; scan (105,53).
  - `a_rom_addr` = 3·32+5 = 101 one cycle later.
  - A ROM model returning 7 → `color_index` = 7, `is_b` = 0 two cycles after the sample.
- **Overlap priority:**
  - Stimulus: A and B both at (200,200); A ROM returns 0 and B ROM returns 2 at the probed pixel.
  - Response: `color_index` = 2, `is_b` = 1.
  - Changing A's data to 1 gives `color_index` = 1, `is_b` = 0.
- **Edge clip:** B at x = 630; scan h = 639 → hit; scan h = 0 on the same row → no hit, output 0.
- **Frame latch:** change `a_x` from 100 to 300 mid-frame with no `frame_start` → pixels still appear at column 100 until the next `frame_start`.
- **Flip (with `SPRITE_FLIP_EN`):** A at (0,0) with face = 1; scan (0,0) → `a_rom_addr` = 31. Without the macro → 0.
